// File: rtl/seq_detector_pkg.sv
// seq_detector_pkg: shared constants and types for the programmable
// serial pattern detector.
package seq_detector_pkg;

    localparam logic [3:0] SEQDET_DEF_PAT = 4'b0010;
    localparam int unsigned SEQDET_DEF_LEN = 4;
    localparam logic SEQDET_DEF_OVERLAP = 1'b1;

    typedef enum logic {
        MODE_NONOVL = 1'b0,
        MODE_OVL    = 1'b1
    } mode_e;

endpackage

// File: rtl/seq_detector_if.sv
// seq_detector_if: serial stream, config and match bundle.
// match_count exists only when SEQDET_COUNT_EN is defined.
interface seq_detector_if #(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1),
    parameter int CNT_W = 8
);
    logic             in;
    logic             in_valid;
    logic             load;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] pat_len;
    logic             overlap;
    logic             out;
    logic             out_q;
`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] match_count;
`endif

    modport master (
        output in, in_valid, load, pattern, pat_len, overlap,
        input  out, out_q
`ifdef SEQDET_COUNT_EN
        , input match_count
`endif
    );

    modport slave (
        input  in, in_valid, load, pattern, pat_len, overlap,
        output out, out_q
`ifdef SEQDET_COUNT_EN
        , output match_count
`endif
    );

endinterface

// File: rtl/seq_sat_counter.sv
// seq_sat_counter: W-bit up counter that sticks at all-ones.
module seq_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detector_prog.sv
// seq_detector_prog: runtime-programmable Mealy serial pattern detector.
// Define SEQDET_COUNT_EN to add the saturating match counter.
module seq_detector_prog
    import seq_detector_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1),
    parameter int CNT_W = 8
) (
    input logic          clk,
    input logic          reset_n,
    seq_detector_if.slave bus
);
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    mode_e            mode_q, mode_d;
    logic [PAT_W-2:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic             outr_q;

    logic [LEN_W-1:0] eff_len;
    logic [PAT_W-1:0] win;
    logic [PAT_W-1:0] mask;
    logic             accept;
    logic             match;

    // Compare only the low eff_len bits of {history, incoming bit}.
    always_comb begin
        eff_len = (len_q > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len_q;
        win     = {hist_q, bus.in};
        mask    = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (LEN_W'(i) < eff_len);
        end
        accept = bus.in_valid && !bus.load;
        match  = accept
              && (eff_len != '0)
              && (fill_q >= (eff_len - LEN_W'(1)))
              && (((win ^ pat_q) & mask) == '0);
    end

    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        mode_d = mode_q;
        hist_d = hist_q;
        fill_d = fill_q;
        if (bus.load) begin
            pat_d  = bus.pattern;
            len_d  = bus.pat_len;
            mode_d = bus.overlap ? MODE_OVL : MODE_NONOVL;
            fill_d = '0;
        end else if (accept) begin
            hist_d = win[PAT_W-2:0];
            if (match && (mode_q == MODE_NONOVL)) begin
                fill_d = '0;
            end else if (fill_q != LEN_W'(PAT_W - 1)) begin
                fill_d = fill_q + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_q  <= PAT_W'(SEQDET_DEF_PAT);
            len_q  <= LEN_W'(SEQDET_DEF_LEN);
            mode_q <= SEQDET_DEF_OVERLAP ? MODE_OVL : MODE_NONOVL;
            hist_q <= '0;
            fill_q <= '0;
            outr_q <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            mode_q <= mode_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            outr_q <= match;
        end
    end

    assign bus.out   = match;
    assign bus.out_q = outr_q;

`ifdef SEQDET_COUNT_EN
    seq_sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (reset_n),
        .inc_i (match),
        .cnt_o (bus.match_count)
    );
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// tb_seq_detector_prog: directed checks of the programmable detector.
// Counter checks are active when SEQDET_COUNT_EN is defined.
module tb_seq_detector_prog;

    localparam int PAT_W = 8;
    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam int CNT_W = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    int checks = 0;
    int errors = 0;
    int step   = 0;
    int cnt_m  = 0;

    always #5 clk = ~clk;

    seq_detector_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    seq_detector_prog #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s step %0d: got %0h want %0h", tag, step, got, exp);
        end
    endtask

    task automatic chk_cnt();
`ifdef SEQDET_COUNT_EN
        chk("match_count", 8'(bus.match_count), 8'(cnt_m));
`endif
    endtask

    // One clock cycle: drive at negedge, check out before the edge,
    // then out_q and the counter just after it.
    task automatic drive(input logic v, input logic b, input logic ld,
                         input logic exp);
        @(negedge clk);
        step++;
        bus.in       = b;
        bus.in_valid = v;
        bus.load     = ld;
        #1;
        chk("out", 8'(bus.out), 8'(exp));
        @(posedge clk);
        #1;
        chk("out_q", 8'(bus.out_q), 8'(exp));
        if (exp) cnt_m = (cnt_m == 3) ? 3 : cnt_m + 1;
        chk_cnt();
        bus.load = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] p, input logic [LEN_W-1:0] l,
                           input logic ov);
        bus.pattern = p;
        bus.pat_len = l;
        bus.overlap = ov;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Bits sent MSB first; exp[n-1-i] is the expected out for bit i.
    task automatic stream(input logic [15:0] bits, input int n,
                          input logic [15:0] exp);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, bits[n-1-i], 1'b0, exp[n-1-i]);
        end
    endtask

    initial begin
        logic [7:0] p8;
        bus.in       = 1'b0;
        bus.in_valid = 1'b0;
        bus.load     = 1'b0;
        bus.pattern  = '0;
        bus.pat_len  = '0;
        bus.overlap  = 1'b0;

        #12;
        chk("rst_out", 8'(bus.out), 8'h0);
        chk("rst_out_q", 8'(bus.out_q), 8'h0);
        chk_cnt();
        @(negedge clk);
        reset_n = 1'b1;

        // Default 0010, overlapping
        stream(16'b0010010, 7, 16'b0001001);

        // Same pattern, non-overlapping
        do_load(8'b0010, 4'd4, 1'b0);
        stream(16'b0010010, 7, 16'b0001000);

        // 8-bit pattern, idle cycles between valid bits
        p8 = 8'b1011_0111;
        do_load(p8, 4'd8, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, p8[7-i], 1'b0, (i == 7));
            if (i < 7) drive(1'b0, 1'b1, 1'b0, 1'b0);
        end

        // Length 0 disables detection
        do_load(8'b0010, 4'd0, 1'b1);
        stream(16'b00100010, 8, 16'h0);

        // Length above PAT_W behaves as PAT_W
        do_load(p8, 4'd9, 1'b1);
        stream(16'hB7, 8, 16'h01);

        // "11" back-to-back, then a bit in a load cycle is dropped
        do_load(8'b11, 4'd2, 1'b1);
        stream(16'b111, 3, 16'b011);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);

        // Async reset mid-stream with out and out_q high
        stream(16'b0011, 4, 16'b0001);
        @(negedge clk);
        step++;
        bus.in       = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        chk("pre_rst_out", 8'(bus.out), 8'h1);
        #1;
        reset_n = 1'b0;
        cnt_m   = 0;
        #1;
        chk("arst_out", 8'(bus.out), 8'h0);
        chk("arst_out_q", 8'(bus.out_q), 8'h0);
        chk_cnt();
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset_n      = 1'b1;

        // Default pattern again; five matches saturate a 2-bit counter
        stream(16'b0010, 4, 16'b0001);
        stream(16'b010010010010, 12, 16'b001001001001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_detector_prog.md
# seq_detector_prog

Programmable, parametrised serial pattern detector; successor to the fixed 4-bit "0010" Mealy detector. It has these features:
- Runtime-loadable pattern of 1..PAT_W bits.
- Overlapping or non-overlapping match mode.
- Bit-valid qualifier.
- Optional saturating match counter.

It sits on serial bit streams (line decoders, framing/sync-word search) and flags the cycle in which the final pattern bit arrives.

## Interface
Parameters:
- PAT_W, 8: maximum pattern length in bits (≥2).
- LEN_W, $clog2(PAT_W+1): width of the length field.
- CNT_W, 8: match counter width (used only with SEQDET_COUNT_EN).

Ports:
- clk, input, 1: rising-edge clock; the only clock.
- reset_n, input, 1: asynchronous, active-low reset.
- in, input, 1: serial data bit.
- in_valid, input, 1: `in` is sampled only when this is high.
- load, input, 1: latch `pattern`, `pat_len` and `overlap` into config registers.
- pattern, input, PAT_W: pattern[pat_len-1] is the first bit expected; pattern[0] is the last.
- pat_len, input, LEN_W: pattern length.
- overlap, input, 1: 1 = overlapping matches allowed; 0 = history cleared after each match.
- out, output, 1: Mealy match flag, combinational on `in` in the completing cycle.
- out_q, output, 1: `out` registered one cycle later.
- match_count, output, CNT_W: saturating count of matches (present only with SEQDET_COUNT_EN).

## Operation
- Config registers reset to: pattern = 'b0010 (zero-extended), len = 4, overlap = 1.
- History register: hist[PAT_W-2:0], shifted left with `in` on each accepted bit.
- Fill counter: fill, 0..PAT_W-1, saturating. It counts valid history bits.
- Length decode:
  - Effective length L = min(cfg_len, PAT_W).
  - cfg_len = 0 disables detection: out is held 0.
- Match condition (combinational): in_valid && !load && fill ≥ L-1 && the low L bits of {hist, in} == the low L bits of cfg_pattern.
- out = match condition.
- On an accepted bit (in_valid && !load):
  - Overlapping, or no match: hist shifts; fill increments (saturating).
  - Match with overlap = 0: fill clears to 0; the hist contents become don't-care.
- Load:
  - Config registers update at the clock edge.
  - fill clears to 0.
  - Any in_valid bit in the same cycle is discarded: not shifted, not matched, not counted.
- in_valid = 0: no state change; out = 0.
- Reset values: out = 0 (fill = 0), out_q = 0, hist = 0, fill = 0, match_count = 0.

## Timing
- Latency 0: out asserts in the same cycle as the last pattern bit.
- out_q follows one cycle later.
- out is only meaningful around the rising edge. It is glitch-prone; consumers needing a clean flag use out_q.
- Throughput: one bit per cycle. Back-to-back matches are possible in overlap mode (e.g. pattern "11", stream "111" gives 2 matches).
- Pattern change mid-stream: the new pattern applies from the first accepted bit after the load edge. Old history is never matched against the new pattern.
- reset_n assertion mid-stream: all state clears immediately and asynchronously, and config returns to 0010/4/overlap. Deassertion is synchronised externally.
- load held high for multiple cycles: config is re-latched each cycle and fill stays 0.

## Configuration
- SEQDET_COUNT_EN defined:
  - match_count port exists.
  - It increments on each cycle where out = 1 and saturates at 2^CNT_W-1.
  - load does not clear it; only reset_n does.
- SEQDET_COUNT_EN undefined: no counter logic and no match_count port. All other behaviour is identical.

## Structure
- Package seq_detector_pkg:
  - Default pattern constant SEQDET_DEF_PAT = 'b0010.
  - SEQDET_DEF_LEN = 4.
  - SEQDET_DEF_OVERLAP = 1.
  - Mode enum {MODE_NONOVL, MODE_OVL}.
- One sub-module, seq_sat_counter: parametrised saturating counter with an increment enable. It is instantiated only under SEQDET_COUNT_EN.
- Matcher, history and fill logic stay inline in seq_detector_prog.

## Test plan
- Reset defaults, overlap = 1, stream 0,0,1,0,0,1,0 all valid:
  - out is high on bits 4 and 7 only.
  - out_q is high one cycle after each.
  - match_count = 2.
- Same stream after load with overlap = 0, pattern 0010, len 4:
  - out is high on bit 4 only.
  - match_count increments by 1.
- load pattern 8'b1011_0111, len 8, then stream 10110111 with in_valid low on every other cycle:
  - Single match on the 8th valid bit.
  - out stays 0 in cycles with in_valid = 0.
- load with len 0: any stream gives out = 0 and no count change. Then load len 9 with PAT_W = 8: behaves as len 8.
- Pattern "11", len 2, overlap = 1, stream 1,1,1 → out high on bits 2 and 3. Then assert load together with a valid 1 → that bit is ignored and the next single 1 gives no match.
- Assert reset_n low mid-pattern, after 0,0,1:
  - out, out_q, fill and match_count return to 0 at once.
  - After release, a fresh 0,0,1,0 is detected with the default pattern.
- With CNT_W = 2 and SEQDET_COUNT_EN, drive 5 matches → match_count saturates at 3.
